// File: rtl/mem_access_stage.sv
// MEM pipeline stage: latches one EX result, runs loads/stores on a req/ready data bus, aligns load data.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module mem_access_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_funct3,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_strb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic                  out_select,
    output logic [DATA_W-1:0]     out_alu_data,
    output logic [DATA_W-1:0]     out_ram_data,
    output logic                  out_reg_write,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  misalign_trap
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
    state_t state_q, state_d;

    logic                  accept, is_mem, trap_now, start_bus;
    logic                  is_byte, is_half;
    logic [1:0]            off;
    logic [3:0]            strb;
    logic [DATA_W-1:0]     wdata;

    logic                  op_load_q, op_rw_q;
    logic [1:0]            op_off_q;
    logic [2:0]            op_f3_q;
    logic [REG_ADDR_W-1:0] op_rd_q;
    logic [DATA_W-1:0]     op_alu_q;
    logic [DATA_W-1:0]     mem_addr_q, mem_wdata_q;
    logic [3:0]            mem_strb_q;
    logic                  mem_we_q;

    logic [DATA_W-1:0]     out_alu_q, out_ram_q;
    logic [REG_ADDR_W-1:0] out_rd_q;
    logic                  out_select_q, out_rw_q, trap_q;

    function automatic logic [DATA_W-1:0] load_align(input logic [DATA_W-1:0] rdata,
                                                     input logic [1:0] o,
                                                     input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*o +: 8];
        h = rdata[16*o[1] +: 16];
        case (f3[1:0])
            2'b00:   return f3[2] ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
            2'b01:   return f3[2] ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    assign accept  = in_valid && (state_q != S_BUS);
    assign is_mem  = in_mem_read | in_mem_write;
    assign is_byte = (in_funct3[1:0] == 2'b00);
    assign is_half = (in_funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign trap_now = is_mem && ((is_half && in_alu_result[0]) ||
                                 (in_funct3[1] && (in_alu_result[1:0] != 2'b00)));
`else
    assign trap_now = 1'b0;
`endif

    assign start_bus = accept && is_mem && !trap_now;

    // Offset is clipped to the access size so misaligned ops behave as aligned ones.
    always_comb begin
        off   = 2'b00;
        strb  = 4'b1111;
        wdata = in_store_data;
        if (is_byte) begin
            off   = in_alu_result[1:0];
            strb  = 4'b0001 << off;
            wdata = {4{in_store_data[7:0]}};
        end else if (is_half) begin
            off   = {in_alu_result[1], 1'b0};
            strb  = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{in_store_data[15:0]}};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BUS:   if (mem_ready) state_d = S_DONE;
            default: begin
                if (accept) state_d = start_bus ? S_BUS : S_DONE;
                else        state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_load_q    <= 1'b0;
            op_rw_q      <= 1'b0;
            op_off_q     <= '0;
            op_f3_q      <= '0;
            op_rd_q      <= '0;
            op_alu_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strb_q   <= '0;
            mem_we_q     <= 1'b0;
            out_alu_q    <= '0;
            out_ram_q    <= '0;
            out_rd_q     <= '0;
            out_select_q <= 1'b0;
            out_rw_q     <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            if (start_bus) begin
                op_load_q   <= in_mem_read;
                op_rw_q     <= in_reg_write;
                op_off_q    <= off;
                op_f3_q     <= in_funct3;
                op_rd_q     <= in_rd;
                op_alu_q    <= in_alu_result;
                mem_addr_q  <= {in_alu_result[DATA_W-1:2], 2'b00};
                mem_wdata_q <= wdata;
                mem_strb_q  <= in_mem_write ? strb : 4'b0000;
                mem_we_q    <= in_mem_write;
            end
            // Completions without a bus phase: plain ALU ops and trapped accesses.
            if (accept && !start_bus) begin
                out_alu_q    <= in_alu_result;
                out_rd_q     <= in_rd;
                out_select_q <= in_mem_read;
                out_rw_q     <= in_reg_write && !is_mem;
                trap_q       <= trap_now;
            end else if (state_q == S_BUS && mem_ready) begin
                out_alu_q    <= op_alu_q;
                out_rd_q     <= op_rd_q;
                out_select_q <= op_load_q;
                out_rw_q     <= op_rw_q && op_load_q;
                trap_q       <= 1'b0;
                if (op_load_q) out_ram_q <= load_align(mem_rdata, op_off_q, op_f3_q);
            end
        end
    end

    assign stall         = (state_q == S_BUS);
    assign mem_req       = (state_q == S_BUS);
    assign mem_we        = mem_req && mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_strb      = mem_strb_q;
    assign out_valid     = (state_q == S_DONE);
    assign out_select    = out_select_q;
    assign out_alu_data  = out_alu_q;
    assign out_ram_data  = out_ram_q;
    assign out_reg_write = out_valid && out_rw_q;
    assign out_rd        = out_rd_q;
    assign misalign_trap = out_valid && trap_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level reference model.
// Honours MISALIGN_TRAP_EN the same way as the design build.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
    logic [31:0] in_alu_result, in_store_data;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        stall, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;
    logic        out_valid, out_select, out_reg_write, misalign_trap;
    logic [31:0] out_alu_data, out_ram_data;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
        .in_reg_write(in_reg_write), .in_rd(in_rd),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_select(out_select), .out_alu_data(out_alu_data),
        .out_ram_data(out_ram_data), .out_reg_write(out_reg_write), .out_rd(out_rd),
        .misalign_trap(misalign_trap)
    );

    int n_pass = 0;
    int n_total = 0;

    // Model: what the stage is expected to show this cycle, plus the held result of the last completion.
    bit          done_flag, e_stall, e_req, e_valid;
    logic [31:0] h_alu, h_ram, h_addr, h_wdata;
    logic [3:0]  h_strb;
    logic [4:0]  h_rd;
    bit          h_sel, h_rw, h_trap, h_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] rdata, input int o, input logic [2:0] f3);
        logic [31:0] v;
        bit          signed_ld;
        signed_ld = (f3 == 3'b000) || (f3 == 3'b001);
        v = rdata >> (8 * o);
        if (size_of(f3) == 1) begin
            v = v & 32'hFF;
            if (signed_ld && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size_of(f3) == 2) begin
            v = v & 32'hFFFF;
            if (signed_ld && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic model_reset();
        done_flag = 0; h_alu = '0; h_ram = '0; h_addr = '0; h_wdata = '0;
        h_strb = '0; h_rd = '0; h_sel = 0; h_rw = 0; h_trap = 0; h_we = 0;
    endtask

    task automatic compare_outputs();
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_reg_write", 32'(out_reg_write), e_valid ? 32'(h_rw) : 32'd0);
        chk("misalign_trap", 32'(misalign_trap), e_valid ? 32'(h_trap) : 32'd0);
        if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(h_we));
            chk("mem_addr", mem_addr, h_addr);
            chk("mem_strb", 32'(mem_strb), 32'(h_strb));
            if (h_we) chk("mem_wdata", mem_wdata, h_wdata);
        end
        if (e_valid) begin
            chk("out_alu_data", out_alu_data, h_alu);
            chk("out_rd", 32'(out_rd), 32'(h_rd));
            if (!h_trap) chk("out_select", 32'(out_select), 32'(h_sel));
            if (h_sel && !h_trap) chk("out_ram_data", out_ram_data, h_ram);
        end
    endtask

    task automatic cycle_check();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_strb"}, 32'(mem_strb), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_select"}, 32'(out_select), 32'd0);
        chk({tag, "_out_alu"}, out_alu_data, 32'd0);
        chk({tag, "_out_ram"}, out_ram_data, 32'd0);
        chk({tag, "_out_rw"}, 32'(out_reg_write), 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_trap"}, 32'(misalign_trap), 32'd0);
    endtask

    task automatic idle();
        in_valid = 0; in_mem_read = 0; in_mem_write = 0;
        in_alu_result = $urandom; in_store_data = $urandom;
        in_funct3 = 3'($urandom_range(0, 7)); in_rd = 5'($urandom_range(0, 31));
        in_reg_write = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        e_stall = 0; e_req = 0; e_valid = done_flag;
        cycle_check();
        done_flag = 0;
    endtask

    // kind: 0 ALU, 1 load, 2 store. w = wait cycles the slave inserts before ready.
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [2:0] f3, input bit rw, input logic [4:0] rd,
                         input int w, input logic [31:0] rdata);
        int          sz, o;
        bit          trap;
        logic [31:0] eff;
        in_valid = 1; in_alu_result = addr; in_store_data = sdata;
        in_mem_read = (kind == 1); in_mem_write = (kind == 2);
        in_funct3 = f3; in_reg_write = rw; in_rd = rd; mem_ready = 0;
        e_stall = 0; e_req = 0; e_valid = done_flag;
        cycle_check();
        done_flag = 0;
        sz = size_of(f3);
        trap = 0;
`ifdef MISALIGN_TRAP_EN
        trap = (kind != 0) && ((addr % sz) != 0);
`endif
        if (kind == 0 || trap) begin
            h_alu = addr; h_rd = rd; h_sel = (kind == 1);
            h_rw = rw && (kind == 0); h_trap = trap; done_flag = 1;
            return;
        end
        eff = addr - (addr % sz);
        o = int'(eff % 4);
        h_addr = eff - 32'(o);
        h_we = (kind == 2);
        h_strb = (kind == 2) ? 4'(((1 << sz) - 1) << o) : 4'd0;
        h_wdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
        for (int i = 0; i <= w; i++) begin
            mem_ready = (i == w);
            mem_rdata = rdata;
            e_stall = 1; e_req = 1; e_valid = 0;
            cycle_check();
        end
        mem_ready = 0;
        h_alu = addr; h_rd = rd; h_sel = (kind == 1);
        h_rw = rw && (kind == 1); h_trap = 0;
        if (kind == 1) h_ram = load_value(rdata, o, f3);
        done_flag = 1;
    endtask

    task automatic reset_during_bus();
        in_valid = 1; in_alu_result = 32'h40; in_store_data = 0; in_mem_read = 1; in_mem_write = 0;
        in_funct3 = 3'b010; in_reg_write = 1; in_rd = 5'd11; mem_ready = 0;
        e_stall = 0; e_req = 0; e_valid = done_flag;
        cycle_check();
        done_flag = 0;
        h_addr = 32'h40; h_we = 0; h_strb = 0;
        e_stall = 1; e_req = 1; e_valid = 0;
        cycle_check();
        #2;
        rst_n = 0;
        #1;
        chk_all_zero("rst_bus");
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] st_f3 [4];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
        rst_n = 0; in_valid = 0; in_alu_result = 0; in_store_data = 0; in_mem_read = 0;
        in_mem_write = 0; in_funct3 = 0; in_reg_write = 0; in_rd = 0; mem_ready = 0; mem_rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        do_op(0, 32'h1234, 0, 3'b010, 1, 5'd5, 0, 0);
        chk("pin_alu_rw", 32'(h_rw), 32'd1);
        idle();
        do_op(1, 32'h103, 0, 3'b000, 1, 5'd7, 0, 32'h80FF_0000);
        chk("pin_lb_addr", h_addr, 32'h100);
        chk("pin_lb_data", h_ram, 32'hFFFF_FF80);
        idle();
        do_op(2, 32'h202, 32'h0000_ABCD, 3'b001, 0, 5'd0, 3, $urandom);
        chk("pin_sh_strb", 32'(h_strb), 32'hC);
        chk("pin_sh_wdata", h_wdata, 32'hABCD_ABCD);
        idle();
        do_op(1, 32'h10, 0, 3'b101, 1, 5'd3, 1, 32'h0000_8001);
        chk("pin_lhu_data", h_ram, 32'h0000_8001);
        do_op(1, 32'h10, 0, 3'b001, 1, 5'd4, 0, 32'h0000_8001);
        chk("pin_lh_data", h_ram, 32'hFFFF_8001);
        idle();
        do_op(1, 32'h21, 0, 3'b010, 1, 5'd9, 2, 32'hDEAD_BEEF);
`ifdef MISALIGN_TRAP_EN
        chk("pin_lw_trap", 32'(h_trap), 32'd1);
`else
        chk("pin_lw_addr", h_addr, 32'h20);
`endif
        idle();
        for (int i = 0; i < 4; i++) do_op(0, $urandom, 0, 3'b000, 1'($urandom_range(0, 1)), 5'(i + 1), 0, 0);
        idle();
        reset_during_bus();
        do_op(0, 32'h55, 0, 3'b000, 1, 5'd12, 0, 0);
        idle();

        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [2:0]  f3;
            kind = $urandom_range(0, 2);
            f3 = (kind == 2) ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 7)];
            do_op(kind, $urandom, $urandom, f3, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
